// File: rtl/alu_pipe_core.sv
// Three-stage (EX/MEM/WB) integer execute core with full forwarding, valid/ready
// handshakes on both sides, status flags and a combinational debug register read.
module alu_pipe_core #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*AW+5:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  localparam int NREG = 1 << AW;
  localparam int SW   = $clog2(XLEN);
  localparam int M    = XLEN - 1;

  localparam logic [5:0] F_NOR  = 6'b000100;
  localparam logic [5:0] F_ADD  = 6'b000101;
  localparam logic [5:0] F_SUB  = 6'b000110;
  localparam logic [5:0] F_NAND = 6'b000111;
  localparam logic [5:0] F_AND  = 6'b001000;
  localparam logic [5:0] F_OR   = 6'b001001;
  localparam logic [5:0] F_XOR  = 6'b001010;
  localparam logic [5:0] F_SLL  = 6'b001011;
  localparam logic [5:0] F_SRL  = 6'b001100;
  localparam logic [5:0] F_SRA  = 6'b001101;
  localparam logic [5:0] F_SLT  = 6'b001110;
  localparam logic [5:0] F_SLTU = 6'b001111;
  localparam logic [5:0] F_LDI  = 6'b010000;

  logic [XLEN-1:0] regs [NREG];

  logic [5:0]      in_funct;
  logic [AW-1:0]   in_rd, in_rs, in_rt;
  logic            stall, accept;
  logic [XLEN-1:0] op_a, op_b;

  logic            ex_valid;
  logic [5:0]      ex_funct;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_a, ex_b;

  logic [XLEN-1:0] alu_res, sum, diff;
  logic [SW-1:0]   sh;
  logic            alu_ovf, alu_ill;

  logic            mem_valid, mem_zero, mem_ovf, mem_ill;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;

  logic            wb_valid, wb_zero, wb_ovf, wb_ill;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  assign in_funct = in_instr[3*AW+5:3*AW];
  assign in_rd    = in_instr[3*AW-1:2*AW];
  assign in_rs    = in_instr[2*AW-1:AW];
  assign in_rt    = in_instr[AW-1:0];

  assign stall    = wb_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Youngest producer wins; r0 and illegal instructions never forward.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] src);
    if (src == '0)                                  return '0;
    if (ex_valid  && !alu_ill && ex_rd  == src)     return alu_res;
    if (mem_valid && !mem_ill && mem_rd == src)     return mem_data;
    if (wb_valid  && !wb_ill  && wb_rd  == src)     return wb_data;
    return regs[src];
  endfunction

  always_comb begin
    op_a = fwd(in_rs);
    op_b = fwd(in_rt);
    if (in_funct == F_LDI) begin
      op_a = XLEN'({in_rs, in_rt});
      op_b = '0;
    end
  end

  assign sum  = ex_a + ex_b;
  assign diff = ex_a - ex_b;
  assign sh   = ex_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ex_funct)
      F_NOR:  alu_res = ~(ex_a | ex_b);
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (ex_a[M] == ex_b[M]) && (sum[M] != ex_a[M]);
      end
      F_SUB: begin
        alu_res = diff;
        alu_ovf = (ex_a[M] != ex_b[M]) && (diff[M] != ex_a[M]);
      end
      F_NAND: alu_res = ~(ex_a & ex_b);
      F_AND:  alu_res = ex_a & ex_b;
      F_OR:   alu_res = ex_a | ex_b;
      F_XOR:  alu_res = ex_a ^ ex_b;
      F_SLL:  alu_res = ex_a << sh;
      F_SRL:  alu_res = ex_a >> sh;
      F_SRA:  alu_res = $signed(ex_a) >>> sh;
      F_SLT:  alu_res = XLEN'($signed(ex_a) < $signed(ex_b));
      F_SLTU: alu_res = XLEN'(ex_a < ex_b);
      F_LDI:  alu_res = ex_a;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_funct  <= '0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_data  <= '0;
      mem_zero  <= 1'b0;
      mem_ovf   <= 1'b0;
      mem_ill   <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_zero   <= 1'b0;
      wb_ovf    <= 1'b0;
      wb_ill    <= 1'b0;
    end else if (!stall) begin
      ex_valid <= accept;
      if (accept) begin
        ex_funct <= in_funct;
        ex_rd    <= in_rd;
        ex_a     <= op_a;
        ex_b     <= op_b;
      end
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_data  <= alu_res;
      mem_zero  <= (alu_res == '0);
      mem_ovf   <= alu_ovf;
      mem_ill   <= alu_ill;
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_data   <= mem_data;
      wb_zero   <= mem_zero;
      wb_ovf    <= mem_ovf;
      wb_ill    <= mem_ill;
    end
  end

  // r0 is never written, so it reads as zero forever after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid && out_ready && !wb_ill && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign out_valid   = wb_valid;
  assign out_rd      = wb_rd;
  assign out_data    = wb_data;
  assign out_zero    = wb_zero;
  assign out_ovf     = wb_ovf;
  assign out_illegal = wb_ill;
  assign dbg_data    = regs[dbg_addr];

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: an architectural model predicts each result
// at accept time; a negedge monitor compares retirements in order.
module tb_alu_pipe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_zero, out_ovf, out_illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_pipe_core #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero, ovf, ill;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          retires = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] a, b, r;
    logic [4:0]  s5;
    longint      s;
    exp_t        e;
    a = mregs[rs];
    b = mregs[rt];
    s5 = b[4:0];
    r = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (f)
      6'h04: r = ~(a | b);
      6'h05: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h06: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h07: r = ~(a & b);
      6'h08: r = a & b;
      6'h09: r = a | b;
      6'h0A: r = a ^ b;
      6'h0B: r = a << s5;
      6'h0C: r = a >> s5;
      6'h0D: r = $signed(a) >>> s5;
      6'h0E: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h0F: r = (a < b) ? 32'd1 : 32'd0;
      6'h10: r = {22'b0, rs, rt};
      default: e.ill = 1'b1;
    endcase
    e.rd   = rd;
    e.data = r;
    e.zero = (r == 32'd0);
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input bit lat = 1'b0);
    int   n;
    exp_t e;
    in_instr = {f, rd, rs, rt};
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 64);
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(f, rd, rs, rt);
    e.acc = cyc;
    e.lat = lat;
    if (!e.ill && rd != 5'd0) mregs[rd] = e.data;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic ldi(input logic [4:0] rd, input logic [9:0] imm);
    issue(6'h10, rd, imm[9:5], imm[4:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("%s_dbg_r%0d", tag, i), dbg_data, mregs[i]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      retires++;
      if (q.size() == 0) begin
        check("unexpected_retire", q.size(), 1);
      end else begin
        e = q.pop_front();
        check("out_rd", out_rd, e.rd);
        check("out_data", out_data, e.data);
        check("out_zero", out_zero, e.zero);
        check("out_ovf", out_ovf, e.ovf);
        check("out_illegal", out_illegal, e.ill);
        if (e.lat) check("latency", cyc - e.acc, 3);
      end
    end
  end

  initial begin
    int          base;
    logic [31:0] snap_data;
    logic [4:0]  snap_rd;
    int          n;

    for (int i = 0; i < 32; i++) mregs[i] = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    out_ready = 1'b1;
    dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_flags", {out_zero, out_ovf, out_illegal}, 0);
    check_regs("rst");

    // Back-to-back dependent chain: ADD forwarded from MEM/EX, SUB from EX.
    @(posedge clk); #1;
    ldi(5'd1, 10'h020);
    ldi(5'd2, 10'h039);
    issue(6'h05, 5'd3, 5'd1, 5'd2, 1'b1);
    issue(6'h06, 5'd4, 5'd3, 5'd3, 1'b1);
    ldi(5'd1, 10'd1);
    ldi(5'd6, 10'd31);
    issue(6'h0B, 5'd2, 5'd1, 5'd6);
    issue(6'h05, 5'd5, 5'd2, 5'd2);
    ldi(5'd8, 10'd4);
    issue(6'h0D, 5'd7, 5'd2, 5'd8);
    issue(6'h0E, 5'd9, 5'd2, 5'd1);
    issue(6'h0F, 5'd9, 5'd2, 5'd1);
    ldi(5'd10, 10'h2AB);
    ldi(5'd11, 10'h155);
    for (int i = 4; i <= 15; i++) issue(6'(i), 5'(i + 8), 5'd10, 5'd11);
    drain();
    check_regs("chain");

    // Backpressure: hold out_ready low while more instructions are offered.
    base = retires;
    out_ready = 1'b0;
    fork
      begin
        ldi(5'd13, 10'h0AA);
        issue(6'h05, 5'd14, 5'd13, 5'd13);
        issue(6'h0A, 5'd15, 5'd14, 5'd13);
        issue(6'h06, 5'd16, 5'd15, 5'd14);
      end
      begin
        n = 0;
        while (!out_valid && n < 32) begin
          @(negedge clk);
          n++;
        end
        check("stall_seen_valid", out_valid, 1);
        snap_data = out_data;
        snap_rd = out_rd;
        for (int k = 0; k < 3; k++) begin
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_data", out_data, snap_data);
          check("stall_out_rd", out_rd, snap_rd);
          if (q.size() != 0) check("stall_head", out_data, q[0].data);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_retire_count", retires - base, 4);
    check_regs("stall");

    // Illegal op must not write or forward; r0 stays zero and never forwards.
    ldi(5'd5, 10'h123);
    issue(6'h3F, 5'd5, 5'd1, 5'd2);
    issue(6'h05, 5'd11, 5'd5, 5'd0);
    ldi(5'd0, 10'h3FF);
    issue(6'h05, 5'd12, 5'd0, 5'd0);
    drain();
    check_regs("illegal");

    // Reset with instructions in flight discards them.
    ldi(5'd17, 10'h011);
    ldi(5'd18, 10'h022);
    ldi(5'd19, 10'h033);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    base = retires;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_retires", retires - base, 0);
    check("post_rst_out_valid", out_valid, 0);
    check_regs("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe_core.md
Name: alu_pipe_core

Overview:
- Parametrised three-stage integer execute core: accepts one register-register instruction per cycle, computes the result, retires it, and writes it back to an internal register file.
- Replaces the fixed-width, hazard-blind datapath. Adds full operand forwarding, a valid/ready handshake on both sides, an extended opcode set, status flags, and a debug read port.

Parameters:
- XLEN, 32: datapath and register width (≥8).
- AW, 5: register address width; NREG = 2^AW registers.
- IW (localparam), 3*AW+6: instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  core can accept.
- in_instr  in  IW  fields: funct [3AW+5:3AW], rd [3AW-1:2AW], rs [2AW-1:AW], rt [AW-1:0].
- out_valid  out  1  retiring result present.
- out_ready  in  1  consumer takes result.
- out_rd  out  AW  destination register.
- out_data  out  XLEN  result.
- out_zero  out  1  out_data == 0.
- out_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- out_illegal  out  1  undefined funct.
- dbg_addr  in  AW  debug register select.
- dbg_data  out  XLEN  registers[dbg_addr], combinational.

Behaviour:
- Reset (async):
  - All stage valid bits clear; in-flight instructions are discarded.
  - All registers are set to 0.
  - out_valid=0, out_data=0, out_rd=0, all flags 0, in_ready=1.
- Register 0 is hardwired to 0. Writes to it are dropped and it is never a forwarding source.
- Pipeline: EX register → MEM register → WB register.
  - Accept (in_valid && in_ready at edge k): decoded funct/rd and both operands are captured into EX.
  - Edge k+1: ALU result and flags are captured into MEM.
  - Edge k+2: they move into WB. out_valid=1 from edge k+2.
  - Minimum latency is 3 cycles; throughput is 1 per cycle.
- Operand read happens at accept time, per source, with priority:
  1. EX stage's live ALU output.
  2. MEM.
  3. WB.
  4. Register file.
  A stage only forwards if it is valid, its rd matches and is ≠0, and it is not illegal. Consequently dependent back-to-back instructions never stall.
- Retire: at the edge where out_valid && out_ready, the register file is written with registers[out_rd]=out_data, unless the instruction is illegal or rd=0.
- Stall = out_valid && !out_ready.
  - All stages hold; in_ready=0.
  - Outputs stay stable; no duplicate write occurs.
  - Bubbles advance only when not stalled.
- funct encoding (A=rs operand, B=rt operand, sh=B[log2(XLEN)-1:0]):
  - 000100 NOR ~(A|B)
  - 000101 ADD A+B (mod 2^XLEN, ovf=signed overflow)
  - 000110 SUB A-B (ovf likewise)
  - 000111 NAND ~(A&B)
  - 001000 AND
  - 001001 OR
  - 001010 XOR
  - 001011 SLL A<<sh
  - 001100 SRL logical
  - 001101 SRA arithmetic
  - 001110 SLT signed → 1/0
  - 001111 SLTU unsigned → 1/0
  - 010000 LDI: result = zero-extended {rs,rt} field (2AW bits); no register reads are needed and forwarding is ignored.
  - Any other funct: result 0, out_illegal=1, no write-back.
- out_zero is computed from the result (1 when the result is 0, including for illegal).
- Simultaneous retire-write and accept-read of the same register: the WB forward supplies the new value.
- rst is asserted during stall: reset wins and the pending result is lost.

Test Plan:
- Reset → dbg_data=0 for every dbg_addr; in_ready=1, out_valid=0.
- LDI r1,0x020; LDI r2,0x039; ADD r3,r1,r2 issued on consecutive cycles with out_ready=1 → third retirement has out_rd=3, out_data=0x00000059, out_zero=0; it appears 3 cycles after its accept; dbg r3=0x59 afterwards.
- SUB r4,r3,r3 immediately after the ADD (EX forward) → out_data=0, out_zero=1, out_ovf=0.
- LDI r1,1; LDI r6,31; SLL r2,r1,r6 → 0x80000000. Then:
  - ADD r5,r2,r2 → 0, out_ovf=1, out_zero=1.
  - SRA r7,r2,r6-derived (LDI r8,4; SRA r7,r2,r8) → 0xF8000000.
  - SLT r9,r2,r1 → 1; SLTU r9,r2,r1 → 0.
- With a result pending, hold out_ready=0 for 3 cycles while in_valid=1 → in_ready=0; out_* stable; one retirement and one write only; after release, pipeline resumes with no lost or duplicated instructions.
- Illegal funct 111111 with rd=5 → out_illegal=1, out_data=0, r5 unchanged. LDI r0,0x3FF → retires, dbg r0=0, a dependent read of r0 returns 0. Assert rst with 3 instructions in flight → out_valid drops immediately, no further retirements, all registers 0.
